lvds_tx: RTL and testbench



---
 rtl/lvds_tx.sv | 196 +++++++++++++++++++
 tb/tb_lvds_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx.sv
// ---------------------------------------------------------------------------
// lvds_tx
//   Modem TX-path serializer. Pulls 32-bit I/Q words from the TX complex FIFO,
//   wraps each into a 32-bit modem frame with sync and control bits, and
//   shifts the frame out two bits per clock as a DDR pair for the TX SB_IO
//   DDR output. The next FIFO word is prefetched during the current frame,
//   so frames follow each other with no idle gap. If no word is ready at a
//   frame boundary while enabled, a zero-sample frame is sent and counted.
//
// Ports
//   i_ddr_clk        DDR bit clock; all logic runs on its rising edge
//   i_rst_b          asynchronous active-low reset
//   i_tx_enable      level; start/stop transmission
//   o_fifo_pull      FIFO read enable, registered one-cycle pulses
//   i_fifo_data      FIFO read data, valid the cycle after o_fifo_pull
//                    ([25:13]=I, [12:0]=Q, [31:26] ignored)
//   i_fifo_empty     FIFO empty flag
//   o_ddr_data       [1]=rising-edge bit (earlier), [0]=falling-edge bit
//   o_busy           high whenever the serializer is not idle
//   o_underrun       sticky underrun flag
//   i_clear_underrun one-cycle pulse; clears o_underrun and o_underrun_cnt
//   o_underrun_cnt   number of underrun frames sent, saturating
// ---------------------------------------------------------------------------
module lvds_tx #(
    parameter int SAMPLE_WIDTH       = 13,
    parameter int UNDERRUN_CNT_WIDTH = 8
) (
    input  logic                          i_ddr_clk,
    input  logic                          i_rst_b,
    input  logic                          i_tx_enable,
    output logic                          o_fifo_pull,
    input  logic [31:0]                   i_fifo_data,
    input  logic                          i_fifo_empty,
    output logic [1:0]                    o_ddr_data,
    output logic                          o_busy,
    output logic                          o_underrun,
    input  logic                          i_clear_underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0] o_underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULL,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    // Zero I and Q samples with the normal sync/control bits.
    localparam logic [31:0] UNDERRUN_FRAME = 32'h80004000;

    // Frame layout {sync 10, I, 0, sync 01, Q, 0} is 32 bits for 13-bit samples.
    function automatic logic [31:0] build_frame(input logic [SAMPLE_WIDTH-1:0] i_s,
                                                input logic [SAMPLE_WIDTH-1:0] q_s);
        return {2'b10, i_s, 1'b0, 2'b01, q_s, 1'b0};
    endfunction

    function automatic logic [UNDERRUN_CNT_WIDTH-1:0] sat_inc(
        input logic [UNDERRUN_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + UNDERRUN_CNT_WIDTH'(1);
    endfunction

    state_t                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [1:0]                    ddr_q, ddr_d;
    logic                          pull_q, pull_d;
    logic                          fetch_q, fetch_d;
    logic                          next_vld_q, next_vld_d;
    logic                          urun_q, urun_d;
    logic [UNDERRUN_CNT_WIDTH-1:0] ucnt_q, ucnt_d;
    logic [29:0]                   sh_q, sh_d;
    logic [31:0]                   next_q, next_d;

    logic [31:0] fifo_frame;
    logic [31:0] load_frame;
    logic        do_load;
    logic        urun_evt;
    logic        unused_fifo_bits;

    assign fifo_frame = build_frame(i_fifo_data[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH],
                                    i_fifo_data[SAMPLE_WIDTH-1:0]);
    assign unused_fifo_bits = ^i_fifo_data[31:2*SAMPLE_WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ddr_d      = ddr_q;
        pull_d     = 1'b0;
        fetch_d    = pull_q;
        next_vld_d = next_vld_q;
        next_d     = next_q;
        sh_d       = sh_q;
        urun_d     = urun_q;
        ucnt_d     = ucnt_q;
        load_frame = fifo_frame;
        do_load    = 1'b0;
        urun_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ddr_d = 2'b00;
                if (i_tx_enable && !i_fifo_empty) begin
                    pull_d  = 1'b1;
                    state_d = ST_PULL;
                end
            end
            ST_PULL: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                do_load = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // fetch_q marks the cycle in which prefetched FIFO data is valid.
                if (fetch_q) begin
                    next_d     = fifo_frame;
                    next_vld_d = 1'b1;
                end
                if (cnt_q != 4'd15) begin
                    ddr_d = sh_q[29:28];
                    sh_d  = {sh_q[27:0], 2'b00};
                    cnt_d = cnt_q + 4'd1;
                    // Pull during count 13 so the word lands at the end of count 14.
                    if (cnt_q == 4'd12 && i_tx_enable && !i_fifo_empty) begin
                        pull_d = 1'b1;
                    end
                end else if (next_vld_q) begin
                    load_frame = next_q;
                    do_load    = 1'b1;
                    next_vld_d = 1'b0;
                end else if (i_tx_enable) begin
                    load_frame = UNDERRUN_FRAME;
                    do_load    = 1'b1;
                    urun_evt   = 1'b1;
                end else begin
                    ddr_d   = 2'b00;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_load) begin
            ddr_d = load_frame[31:30];
            sh_d  = load_frame[29:0];
            cnt_d = 4'd0;
        end

        // A clear coinciding with an underrun wins; the next underrun counts from 0.
        if (i_clear_underrun) begin
            urun_d = 1'b0;
            ucnt_d = '0;
        end else if (urun_evt) begin
            urun_d = 1'b1;
            ucnt_d = sat_inc(ucnt_q);
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            ddr_q      <= 2'b00;
            pull_q     <= 1'b0;
            fetch_q    <= 1'b0;
            next_vld_q <= 1'b0;
            urun_q     <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ddr_q      <= ddr_d;
            pull_q     <= pull_d;
            fetch_q    <= fetch_d;
            next_vld_q <= next_vld_d;
            urun_q     <= urun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    // Frame data registers are always qualified by control state, so no reset.
    always_ff @(posedge i_ddr_clk) begin
        sh_q   <= sh_d;
        next_q <= next_d;
    end

    assign o_ddr_data     = ddr_q;
    assign o_fifo_pull    = pull_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_underrun     = urun_q;
    assign o_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_lvds_tx.sv
module tb_lvds_tx;

    localparam logic [31:0] URUN = 32'h80004000;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        pull;
    logic [1:0]  ddr;
    logic        busy;
    logic        urun;
    logic [7:0]  ucnt;

    always #5 clk = ~clk;

    lvds_tx #(.SAMPLE_WIDTH(13), .UNDERRUN_CNT_WIDTH(8)) dut (
        .i_ddr_clk        (clk),
        .i_rst_b          (rst_b),
        .i_tx_enable      (en),
        .o_fifo_pull      (pull),
        .i_fifo_data      (fifo_data),
        .i_fifo_empty     (fifo_empty),
        .o_ddr_data       (ddr),
        .o_busy           (busy),
        .o_underrun       (urun),
        .i_clear_underrun (clr),
        .o_underrun_cnt   (ucnt)
    );

    int checks = 0;
    int failures = 0;

    // FIFO model: words written by the stimulus side, read by the model process.
    logic [31:0] word_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pulls_total = 0;
    int          pop_empty_errs = 0;
    bit          pull_flag = 1'b0;

    // Expected frames, in transmit order.
    logic [31:0] exp_q [$];

    always @(negedge clk) pull_flag = pull;

    always begin
        @(posedge clk);
        #1;
        if (pull_flag) begin
            pulls_total++;
            if (rd_ptr == wr_ptr) begin
                pop_empty_errs++;
                fifo_data = $urandom;
            end else begin
                fifo_data = word_mem[rd_ptr];
                rd_ptr++;
            end
        end else begin
            fifo_data = $urandom;
        end
        fifo_empty = (rd_ptr == wr_ptr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_frame(input logic [31:0] w);
        return {2'b10, w[25:13], 1'b0, 2'b01, w[12:0], 1'b0};
    endfunction

    task automatic push_fifo(input logic [31:0] w);
        word_mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_start(input int bound, output int lat);
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (ddr === 2'b10) begin
                lat = i;
                break;
            end
        end
    endtask

    // Compares one frame (or its first stop_at pairs) against the scoreboard,
    // plus the per-cycle pull/busy pattern. Optionally drops enable at pair drop_at.
    task automatic check_frame(input bit adv, input bit pull13, input int drop_at,
                               input int stop_at);
        logic [31:0] expf, got, mask;
        logic [15:0] pg, pe, bg, be;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected frame queued");
            return;
        end
        expf = exp_q.pop_front();
        got = '0; mask = '0; pg = '0; pe = '0; bg = '0; be = '0;
        for (int k = 0; k < stop_at; k++) begin
            if (k > 0 || adv) @(negedge clk);
            got[31-2*k -: 2]  = ddr;
            mask[31-2*k -: 2] = 2'b11;
            pg[k] = pull;
            pe[k] = pull13 && (k == 13);
            bg[k] = busy;
            be[k] = 1'b1;
            if (k == drop_at) en = 1'b0;
        end
        if ((got & mask) !== (expf & mask)) begin
            failures++;
            $display("FAIL frame_data: got %h required %h (mask %h)", got, expf, mask);
        end
        checks++;
        if ({pg, bg} !== {pe, be}) begin
            failures++;
            $display("FAIL frame_ctl: pull %b busy %b required pull %b busy %b", pg, bg, pe, be);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if ({ddr, busy} !== 3'b000) begin
            failures++;
            $display("FAIL %s: ddr=%b busy=%b required ddr=00 busy=0", name, ddr, busy);
        end
    endtask

    task automatic check_lat(input int lat, input string name);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL %s: first pair after %0d cycles required 3", name, lat);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({ddr, pull, busy, urun, ucnt} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0", {ddr, pull, busy, urun, ucnt});
        end
        rst_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({ddr, pull, busy, urun, ucnt} !== 13'd0) begin
                failures++;
                $display("FAIL idle_after_reset: cycle %0d got %b required 0", i,
                         {ddr, pull, busy, urun, ucnt});
            end
        end
    endtask

    task automatic test_single(input logic [31:0] w, input logic [31:0] expf);
        int lat;
        int p0;
        p0 = pulls_total;
        push_fifo(w);
        exp_q.push_back(expf);
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_start(10, lat);
        check_lat(lat, "single_latency");
        en = 1'b0;
        check_frame(1'b0, 1'b0, -1, 16);
        check_idle("single_idle");
        checks++;
        if (pulls_total - p0 !== 1) begin
            failures++;
            $display("FAIL single_pulls: got %0d required 1", pulls_total - p0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int p0;
        logic [31:0] w;
        p0 = pulls_total;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            push_fifo(w);
            exp_q.push_back(model_frame(w));
        end
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_start(10, lat);
        check_lat(lat, "b2b_latency");
        for (int f = 0; f < 8; f++) begin
            check_frame(f != 0, f < 7, -1, 16);
            if (f == 0) begin
                checks++;
                if (urun !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_no_underrun: got %b required 0", urun);
                end
            end
        end
        checks++;
        if (pulls_total - p0 !== 8) begin
            failures++;
            $display("FAIL b2b_pulls: got %0d required 8", pulls_total - p0);
        end
        for (int u = 1; u <= 3; u++) begin
            exp_q.push_back(URUN);
            check_frame(1'b1, 1'b0, -1, 16);
            checks++;
            if ({urun, ucnt} !== {1'b1, u[7:0]}) begin
                failures++;
                $display("FAIL underrun_count: flag=%b cnt=%0d required flag=1 cnt=%0d",
                         urun, ucnt, u);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_c;
        for (int u = 4; u <= 300; u++) begin
            exp_q.push_back(URUN);
            check_frame(1'b1, 1'b0, -1, 16);
            if (u == 255 || u == 256 || u == 300) begin
                exp_c = (u > 255) ? 8'd255 : u[7:0];
                checks++;
                if ({urun, ucnt} !== {1'b1, exp_c}) begin
                    failures++;
                    $display("FAIL underrun_sat: frame %0d flag=%b cnt=%0d required flag=1 cnt=%0d",
                             u, urun, ucnt, exp_c);
                end
            end
        end
        // Clear pulse on the same edge as the next underrun frame load.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_q.push_back(URUN);
        check_frame(1'b0, 1'b0, -1, 16);
        checks++;
        if ({urun, ucnt} !== 9'd0) begin
            failures++;
            $display("FAIL clear_wins: flag=%b cnt=%0d required flag=0 cnt=0", urun, ucnt);
        end
        exp_q.push_back(URUN);
        check_frame(1'b1, 1'b0, 15, 16);
        checks++;
        if ({urun, ucnt} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL count_after_clear: flag=%b cnt=%0d required flag=1 cnt=1", urun, ucnt);
        end
        check_idle("underrun_stop_idle");
    endtask

    task automatic test_disable_prefetch(input logic [31:0] c_word);
        int lat;
        int p0;
        logic [31:0] a, b;
        p0 = pulls_total;
        a = $urandom;
        b = $urandom;
        push_fifo(a);
        exp_q.push_back(model_frame(a));
        push_fifo(b);
        exp_q.push_back(model_frame(b));
        push_fifo(c_word);
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_start(10, lat);
        check_lat(lat, "prefetch_latency");
        check_frame(1'b0, 1'b1, 14, 16);
        check_frame(1'b1, 1'b0, -1, 16);
        check_idle("prefetch_idle");
        checks++;
        if (pulls_total - p0 !== 2) begin
            failures++;
            $display("FAIL prefetch_pulls: got %0d required 2", pulls_total - p0);
        end
        checks++;
        if (wr_ptr - rd_ptr !== 1) begin
            failures++;
            $display("FAIL prefetch_fifo_left: got %0d required 1", wr_ptr - rd_ptr);
        end
    endtask

    task automatic test_async_reset(input logic [31:0] c_word);
        int lat;
        int p0;
        logic [31:0] d;
        p0 = pulls_total;
        d = $urandom;
        push_fifo(d);
        exp_q.push_back(model_frame(c_word));
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_start(10, lat);
        check_lat(lat, "areset_latency");
        check_frame(1'b0, 1'b0, -1, 8);
        rst_b = 1'b0;
        #1;
        checks++;
        if ({ddr, pull, busy, urun, ucnt} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got %b required 0", {ddr, pull, busy, urun, ucnt});
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({pull, busy} !== 2'b00) begin
                failures++;
                $display("FAIL no_pull_after_reset: cycle %0d pull=%b busy=%b required 0 0",
                         i, pull, busy);
            end
        end
        checks++;
        if (pulls_total - p0 !== 1) begin
            failures++;
            $display("FAIL areset_pulls: got %0d required 1", pulls_total - p0);
        end
        exp_q.push_back(model_frame(d));
        en = 1'b1;
        wait_start(10, lat);
        check_lat(lat, "restart_latency");
        en = 1'b0;
        check_frame(1'b0, 1'b0, -1, 16);
        check_idle("restart_idle");
    endtask

    initial begin
        logic [31:0] c_word;
        c_word = $urandom;
        test_reset();
        test_single(32'h00001001, 32'h80006002);
        test_single(32'h01FFF000, 32'h9FFE6000);
        test_back_to_back();
        test_saturation();
        test_disable_prefetch(c_word);
        test_async_reset(c_word);
        checks++;
        if (pop_empty_errs !== 0) begin
            failures++;
            $display("FAIL pull_on_empty: got %0d required 0", pop_empty_errs);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL frames_left: got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
